// File: rtl/glip_uart_autobaud.sv
// Baud-rate calibration ahead of the UART receiver. It synchronizes uart_rx, times one 0x55
// sync character and publishes the measured clk-cycles-per-bit divisor.
module glip_uart_autobaud #(
    parameter int unsigned DIV_WIDTH       = 16,
    parameter int unsigned MIN_DIVISOR     = 8,
    parameter int unsigned DEFAULT_DIVISOR = 434
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    output logic                 rx_sync,
    input  logic                 start,
    output logic                 busy,
    output logic [DIV_WIDTH-1:0] divisor,
    output logic                 divisor_valid,
    output logic                 error
);
    localparam int unsigned CntW = DIV_WIDTH + 3;
    localparam int unsigned IvlW = DIV_WIDTH + 1;

    localparam logic [CntW-1:0]      CntMax   = {CntW{1'b1}};
    localparam logic [IvlW-1:0]      IvlMax   = {IvlW{1'b1}};
    localparam logic [CntW-1:0]      CntOne   = CntW'(1);
    localparam logic [IvlW-1:0]      IvlOne   = IvlW'(1);
    localparam logic [IvlW-1:0]      HighLast = IvlW'(15);
    localparam logic [CntW:0]        RoundAdd = (CntW + 1)'(4);
    localparam logic [DIV_WIDTH:0]   MinDiv   = (DIV_WIDTH + 1)'(MIN_DIVISOR);
    localparam logic [DIV_WIDTH-1:0] DefDiv   = DIV_WIDTH'(DEFAULT_DIVISOR);

    typedef enum logic [2:0] {
        StIdle, StWaitHigh, StWaitStart, StMeasure, StWaitStop, StStopHigh, StDone, StErr
    } state_e;

    state_e               state_q, state_d;
    logic                 sync1_q, sync2_q, prev_q;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [IvlW-1:0]      ivl_q, ivl_d;
    logic [IvlW-1:0]      ref_q, ref_d;
    logic [1:0]           edges_q, edges_d;
    logic                 busy_q;
    logic [DIV_WIDTH-1:0] divisor_q, divisor_d;
    logic                 valid_q, valid_d;

    logic               fall, rise;
    logic [IvlW-1:0]    ivl_diff;
    logic [CntW:0]      div_sum;
    logic [DIV_WIDTH:0] div_new;
    logic               div_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            ivl_q     <= '0;
            ref_q     <= '0;
            edges_q   <= '0;
            busy_q    <= 1'b0;
            divisor_q <= DefDiv;
            valid_q   <= 1'b0;
        end else begin
            sync1_q   <= uart_rx;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ivl_q     <= ivl_d;
            ref_q     <= ref_d;
            edges_q   <= edges_d;
            busy_q    <= (state_d != StIdle);
            divisor_q <= divisor_d;
            valid_q   <= valid_d;
        end
    end

    assign fall     = prev_q & ~sync2_q;
    assign rise     = ~prev_q & sync2_q;
    assign ivl_diff = (ivl_q >= ref_q) ? (ivl_q - ref_q) : (ref_q - ivl_q);
    // cnt spans eight bit times, so divide by 8 rounding half up
    assign div_sum  = {1'b0, cnt_q} + RoundAdd;
    assign div_new  = (DIV_WIDTH + 1)'(div_sum >> 3);
    assign div_ok   = !div_new[DIV_WIDTH] && (div_new >= MinDiv);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ivl_d     = ivl_q;
        ref_d     = ref_q;
        edges_d   = edges_q;
        divisor_d = divisor_q;
        valid_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StWaitHigh;
                    ivl_d   = '0;
                end
            end
            StWaitHigh: begin
                if (!sync2_q) begin
                    ivl_d = '0;
                end else if (ivl_q == HighLast) begin
                    state_d = StWaitStart;
                end else begin
                    ivl_d = ivl_q + IvlOne;
                end
            end
            StWaitStart: begin
                if (fall) begin
                    state_d = StMeasure;
                    cnt_d   = CntOne;
                    ivl_d   = IvlOne;
                    edges_d = '0;
                end
            end
            StMeasure: begin
                cnt_d = cnt_q + CntOne;
                ivl_d = ivl_q + IvlOne;
                if (cnt_q == CntMax || ivl_q == IvlMax) begin
                    state_d = StErr;
                end else if (fall) begin
                    ivl_d   = IvlOne;
                    edges_d = edges_q + 2'd1;
                    if (edges_q == 2'd0) begin
                        ref_d = ivl_q;
                    end else if (ivl_diff > (ref_q >> 3)) begin
                        state_d = StErr;
                    end else if (edges_q == 2'd3) begin
                        // F4: freeze cnt, ivl now times the stop-bit phase
                        state_d = StWaitStop;
                        cnt_d   = cnt_q;
                    end
                end
            end
            StWaitStop: begin
                ivl_d = ivl_q + IvlOne;
                if (ivl_q > ref_q) begin
                    state_d = StErr;
                end else if (rise) begin
                    state_d = StStopHigh;
                    ivl_d   = IvlOne;
                end
            end
            StStopHigh: begin
                ivl_d = ivl_q + IvlOne;
                if (fall) begin
                    state_d = StErr;
                end else if (ivl_q >= (ref_q >> 2)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (div_ok) begin
                    divisor_d = div_new[DIV_WIDTH-1:0];
                    valid_d   = 1'b1;
                    state_d   = StIdle;
                end else begin
                    state_d = StErr;
                end
            end
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign rx_sync       = sync2_q;
    assign busy          = busy_q;
    assign divisor       = divisor_q;
    assign divisor_valid = valid_q;
    assign error         = (state_q == StErr);

endmodule

// File: tb/tb_glip_uart_autobaud.sv
// Bench for glip_uart_autobaud: expected calibration results are queued as frames are sent and
// a monitor compares them against every divisor_valid / error pulse.
module tb_glip_uart_autobaud;
    localparam int unsigned W      = 16;
    localparam int unsigned MinDiv = 8;
    localparam int unsigned DefDiv = 434;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         uart_rx = 1'b1;
    logic         start = 1'b0;
    logic         rx_sync, busy, divisor_valid, error;
    logic [W-1:0] divisor;

    logic       rx8 = 1'b1;
    logic       start8 = 1'b0;
    logic       rx_sync8, busy8, dv8, err8;
    logic [7:0] div8;

    always #5 clk = ~clk;

    glip_uart_autobaud #(.DIV_WIDTH(W), .MIN_DIVISOR(MinDiv), .DEFAULT_DIVISOR(DefDiv)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .rx_sync(rx_sync), .start(start), .busy(busy),
        .divisor(divisor), .divisor_valid(divisor_valid), .error(error)
    );

    glip_uart_autobaud #(.DIV_WIDTH(8), .MIN_DIVISOR(8), .DEFAULT_DIVISOR(100)) dut8 (
        .clk(clk), .rst(rst), .uart_rx(rx8), .rx_sync(rx_sync8), .start(start8), .busy(busy8),
        .divisor(div8), .divisor_valid(dv8), .error(err8)
    );

    typedef struct {
        bit          err;
        int unsigned div;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned model_div = DefDiv;
    int          dur[10];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: falls open bits 0,2,4,6,8 of the frame; judge intervals, timing and range.
    function automatic exp_t model_frame(input int unsigned w);
        exp_t        r;
        int unsigned ivl_max = (1 << (w + 1)) - 1;
        int unsigned cnt_max = (1 << (w + 3)) - 1;
        int unsigned refv = 0, iv, dev, cnt = 0, d;
        r.err = 1'b0;
        r.div = model_div;
        for (int k = 0; k < 4; k++) begin
            iv = dur[2*k] + dur[2*k+1];
            cnt += iv;
            if (k == 0) refv = iv;
            dev = (iv > refv) ? iv - refv : refv - iv;
            if (iv >= ivl_max || dev > refv / 8) r.err = 1'b1;
        end
        if (cnt >= cnt_max || dur[8] > refv) r.err = 1'b1;
        if (!r.err) begin
            d = (cnt + 4) / 8;
            if (d < MinDiv || d > (1 << w) - 1) r.err = 1'b1;
            else r.div = d;
        end
        return r;
    endfunction

    task automatic push_expect();
        exp_t e;
        e = model_frame(W);
        exp_q.push_back(e);
        model_div = e.div;
    endtask

    task automatic drive_level(input logic v, input int n);
        uart_rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame();
        for (int i = 0; i < 10; i++) drive_level(i % 2 == 1, dur[i]);
    endtask

    task automatic set_uniform(input int p);
        for (int i = 0; i < 10; i++) dur[i] = p;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        check("drain_pending_results", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("busy_after_result", 32'(busy), 0);
    endtask

    task automatic run_frame(input int idle_after);
        push_expect();
        pulse_start();
        check("busy_after_start", 32'(busy), 1);
        drive_level(1'b1, 20);
        send_frame();
        drive_level(1'b1, idle_after);
        drain(idle_after + 2000);
    endtask

    initial begin
        exp_t e;
        fork
            forever begin
                @(negedge clk);
                if (!rst && (divisor_valid || error)) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse: valid=%0b error=%0b divisor=%0d, expected none",
                                 divisor_valid, error, divisor);
                    end else begin
                        e = exp_q.pop_front();
                        check("result_error", 32'(error), 32'(e.err));
                        check("result_valid", 32'(divisor_valid), 32'(!e.err));
                        check("result_divisor", 32'(divisor), e.div);
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("reset_rx_sync", 32'(rx_sync), 1);
        check("reset_busy", 32'(busy), 0);
        check("reset_divisor", 32'(divisor), DefDiv);
        check("reset_valid", 32'(divisor_valid), 0);
        check("reset_error", 32'(error), 0);
        check("reset_divisor_w8", 32'(div8), 100);
        check("reset_rx_sync_w8", 32'(rx_sync8), 1);
        rst = 1'b0;
        drive_level(1'b1, 5);

        // Nominal 115200 baud at 50 MHz
        set_uniform(434);
        run_frame(900);
        check("nominal_divisor_held", 32'(divisor), 434);

        // Third interval 1000 vs ref 868 exceeds tolerance
        set_uniform(434);
        dur[4] = 500;
        dur[5] = 500;
        run_frame(900);
        check("jitter_divisor_unchanged", 32'(divisor), 434);

        // F0->F4 = 804 rounds to 101, 803 rounds to 100
        for (int i = 0; i < 10; i++) dur[i] = (i % 2 == 0) ? 100 : 101;
        run_frame(300);
        for (int i = 0; i < 10; i++) dur[i] = (i % 2 == 0) ? 100 : 101;
        dur[7] = 100;
        run_frame(300);

        // 4 cycles per bit is below the minimum divisor
        set_uniform(4);
        run_frame(60);
        check("min_divisor_unchanged", 32'(divisor), 100);

        // Glitch during the idle wait, then a frame whose high runs are too short to qualify
        pulse_start();
        drive_level(1'b1, 10);
        drive_level(1'b0, 3);
        drive_level(1'b1, 10);
        set_uniform(10);
        send_frame();
        drive_level(1'b1, 60);
        pulse_start();
        drive_level(1'b1, 3);
        set_uniform(30);
        push_expect();
        send_frame();
        drive_level(1'b1, 100);
        drain(2000);

        for (int t = 0; t < 10; t++) begin
            int p, j;
            p = int'($urandom_range(150, 6));
            j = ($urandom_range(3, 0) == 0) ? p / 3 : p / 16;
            for (int i = 0; i < 10; i++) dur[i] = p - j + int'($urandom_range(2 * j, 0));
            dur[9] = p;
            run_frame(4 * p + 40);
        end

        // Abort mid-measure with async reset after a known calibration
        set_uniform(50);
        run_frame(200);
        check("pre_abort_divisor", 32'(divisor), model_div);
        pulse_start();
        drive_level(1'b1, 20);
        drive_level(1'b0, 50);
        drive_level(1'b1, 50);
        drive_level(1'b0, 20);
        #3 rst = 1'b1;
        #1;
        model_div = DefDiv;
        check("abort_divisor", 32'(divisor), DefDiv);
        check("abort_busy", 32'(busy), 0);
        check("abort_rx_sync", 32'(rx_sync), 1);
        check("abort_valid", 32'(divisor_valid), 0);
        check("abort_error", 32'(error), 0);
        uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        drive_level(1'b1, 40);
        check("post_abort_divisor", 32'(divisor), DefDiv);

        // Narrow instance: line stuck low after F0 must saturate the interval counter
        begin
            bit got_err = 1'b0;
            bit got_dv = 1'b0;
            start8 = 1'b1;
            @(posedge clk);
            #1;
            start8 = 1'b0;
            repeat (20) @(posedge clk);
            #1;
            rx8 = 1'b0;
            for (int n = 0; n < 1500; n++) begin
                @(negedge clk);
                if (dv8) got_dv = 1'b1;
                if (err8) begin
                    got_err = 1'b1;
                    break;
                end
            end
            check("sat_error_seen", 32'(got_err), 1);
            check("sat_no_valid", 32'(got_dv), 0);
            check("sat_divisor_kept", 32'(div8), 100);
            rx8 = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
